// File: rtl/rf_restore_pkg.sv
// Shared types for the recovery-RF restore sequencer: FSM state codes, write-beat struct,
// and last-address helper. Optional build macro: RF_RESTORE_SINGLE_PORT_EN.
package rf_restore_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StRead  = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

  // Beat fields are sized for the widest supported configuration and sliced at use.
  localparam int unsigned BeatAddrW = 7;
  localparam int unsigned BeatDataW = 64;

  typedef struct packed {
    logic [BeatAddrW-1:0] addr;
    logic [BeatDataW-1:0] data;
    logic                 valid;
  } rf_beat_t;

  function automatic int unsigned last_addr(input int unsigned fpu, input int unsigned zfinx);
    return (fpu != 0 && zfinx == 0) ? 32'd63 : 32'd31;
  endfunction

endpackage

// File: rtl/rf_restore_addr_gen.sv
// Restore address counter: issues one or two addresses per advance and flags the final issue.
// With RF_RESTORE_SINGLE_PORT_EN defined only port A addresses are produced.
module rf_restore_addr_gen
  import rf_restore_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned FPU        = 0,
  parameter int unsigned PULP_ZFINX = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] cnt_a_o,
  output logic [ADDR_WIDTH-1:0] cnt_b_o,
  output logic                  valid_b_o,
  output logic                  last_o
);

  localparam int unsigned LastAddr = last_addr(FPU, PULP_ZFINX);
  // One spare bit so the counter can step past the top address without wrapping.
  localparam int unsigned CntW     = ADDR_WIDTH + 1;

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_last;

  assign w_last  = CntW'(LastAddr);
  assign cnt_a_o = r_cnt[ADDR_WIDTH-1:0];

`ifdef RF_RESTORE_SINGLE_PORT_EN
  localparam int unsigned Step = 1;

  assign cnt_b_o   = '0;
  assign valid_b_o = 1'b0;
  assign last_o    = (r_cnt == w_last);
`else
  localparam int unsigned Step = 2;

  logic [CntW-1:0] w_cnt_b;

  assign w_cnt_b   = r_cnt + CntW'(1);
  assign cnt_b_o   = w_cnt_b[ADDR_WIDTH-1:0];
  assign valid_b_o = (w_cnt_b <= w_last);
  assign last_o    = (r_cnt == w_last) || (w_cnt_b == w_last);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_cnt <= CntW'(1);
    end else if (advance_i) begin
      r_cnt <= r_cnt + CntW'(Step);
    end
  end

endmodule

// File: rtl/rf_restore_sequencer.sv
// Replays the recovery register file into the core RF write ports after a fault.
// Define RF_RESTORE_SINGLE_PORT_EN to restore one register per cycle on port A only.
module rf_restore_sequencer
  import rf_restore_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned FPU        = 0,
  parameter int unsigned PULP_ZFINX = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stall_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] raddr_a_o,
  output logic [ADDR_WIDTH-1:0] raddr_b_o,
  input  logic [DataWidth-1:0]  rdata_a_i,
  input  logic [DataWidth-1:0]  rdata_b_i,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DataWidth-1:0]  wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DataWidth-1:0]  wdata_b_o,
  output logic                  we_b_o
);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] w_cnt_a;
  logic [ADDR_WIDTH-1:0] w_cnt_b;
  logic                  w_valid_b;
  logic                  w_last;
  logic                  w_reading;
  rf_beat_t              r_beat_a;

  assign w_reading = (r_state == StRead);

  rf_restore_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .FPU        (FPU),
    .PULP_ZFINX (PULP_ZFINX)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (r_state == StIdle),
    .advance_i (w_reading && !stall_i),
    .cnt_a_o   (w_cnt_a),
    .cnt_b_o   (w_cnt_b),
    .valid_b_o (w_valid_b),
    .last_o    (w_last)
  );

  always_comb begin
    w_state_next = r_state;
    if (!stall_i) begin
      unique case (r_state)
        StIdle:  if (start_i) w_state_next = StRead;
        StRead:  if (w_last) w_state_next = StDrain;
        StDrain: w_state_next = StDone;
        StDone:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_beat_a <= '0;
    end else if (!stall_i) begin
      if (w_reading) begin
        r_beat_a <= '{addr: BeatAddrW'(w_cnt_a), data: BeatDataW'(rdata_a_i), valid: 1'b1};
      end else begin
        r_beat_a <= '0;
      end
    end
  end

  assign busy_o    = (r_state == StRead) || (r_state == StDrain);
  // Gated so a stall while in DONE never stretches the pulse.
  assign done_o    = (r_state == StDone) && !stall_i;
  assign raddr_a_o = w_reading ? w_cnt_a : '0;
  assign we_a_o    = r_beat_a.valid && !stall_i;
  assign waddr_a_o = r_beat_a.addr[ADDR_WIDTH-1:0];
  assign wdata_a_o = r_beat_a.data[DataWidth-1:0];

`ifdef RF_RESTORE_SINGLE_PORT_EN
  logic w_unused_beat;
  assign w_unused_beat = ^{r_beat_a, rdata_b_i, w_cnt_b, w_valid_b};

  assign raddr_b_o = '0;
  assign we_b_o    = 1'b0;
  assign waddr_b_o = '0;
  assign wdata_b_o = '0;
`else
  rf_beat_t r_beat_b;
  logic     w_unused_beat;
  assign w_unused_beat = ^{r_beat_a, r_beat_b};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_beat_b <= '0;
    end else if (!stall_i) begin
      if (w_reading) begin
        r_beat_b <= '{addr: BeatAddrW'(w_cnt_b), data: BeatDataW'(rdata_b_i), valid: w_valid_b};
      end else begin
        r_beat_b <= '0;
      end
    end
  end

  assign raddr_b_o = w_reading ? w_cnt_b : '0;
  assign we_b_o    = r_beat_b.valid && !stall_i;
  assign waddr_b_o = r_beat_b.addr[ADDR_WIDTH-1:0];
  assign wdata_b_o = r_beat_b.data[DataWidth-1:0];
`endif

endmodule

// File: tb/tb_rf_restore_sequencer.sv
// Directed bench for rf_restore_sequencer: integer-only and FP-bank instances share clock and reset.
module tb_rf_restore_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stall, sel_fp;

  logic [4:0]  i_ra_a, i_ra_b, i_wa_a, i_wa_b;
  logic [31:0] i_rd_a, i_rd_b, i_wd_a, i_wd_b;
  logic        i_we_a, i_we_b, i_busy, i_done;
  logic [5:0]  f_ra_a, f_ra_b, f_wa_a, f_wa_b;
  logic [31:0] f_rd_a, f_rd_b, f_wd_a, f_wd_b;
  logic        f_we_a, f_we_b, f_busy, f_done;

  // Recovery RF model: register k holds 0xA000_0000 + k.
  assign i_rd_a = 32'hA000_0000 + 32'(i_ra_a);
  assign i_rd_b = 32'hA000_0000 + 32'(i_ra_b);
  assign f_rd_a = 32'hA000_0000 + 32'(f_ra_a);
  assign f_rd_b = 32'hA000_0000 + 32'(f_ra_b);

  rf_restore_sequencer #(
    .ADDR_WIDTH (5), .DataWidth (32), .FPU (0), .PULP_ZFINX (0)
  ) u_dut_int (
    .clk_i (clk), .rst_i (rst), .start_i (start && !sel_fp), .stall_i (stall),
    .busy_o (i_busy), .done_o (i_done),
    .raddr_a_o (i_ra_a), .raddr_b_o (i_ra_b), .rdata_a_i (i_rd_a), .rdata_b_i (i_rd_b),
    .waddr_a_o (i_wa_a), .wdata_a_o (i_wd_a), .we_a_o (i_we_a),
    .waddr_b_o (i_wa_b), .wdata_b_o (i_wd_b), .we_b_o (i_we_b)
  );

  rf_restore_sequencer #(
    .ADDR_WIDTH (6), .DataWidth (32), .FPU (1), .PULP_ZFINX (0)
  ) u_dut_fp (
    .clk_i (clk), .rst_i (rst), .start_i (start && sel_fp), .stall_i (stall),
    .busy_o (f_busy), .done_o (f_done),
    .raddr_a_o (f_ra_a), .raddr_b_o (f_ra_b), .rdata_a_i (f_rd_a), .rdata_b_i (f_rd_b),
    .waddr_a_o (f_wa_a), .wdata_a_o (f_wd_a), .we_a_o (f_we_a),
    .waddr_b_o (f_wa_b), .wdata_b_o (f_wd_b), .we_b_o (f_we_b)
  );

  logic [5:0]  m_ra_a, m_ra_b, m_wa_a, m_wa_b;
  logic [31:0] m_wd_a, m_wd_b;
  logic        m_we_a, m_we_b, m_busy, m_done;

  assign m_ra_a = sel_fp ? f_ra_a : {1'b0, i_ra_a};
  assign m_ra_b = sel_fp ? f_ra_b : {1'b0, i_ra_b};
  assign m_wa_a = sel_fp ? f_wa_a : {1'b0, i_wa_a};
  assign m_wa_b = sel_fp ? f_wa_b : {1'b0, i_wa_b};
  assign m_wd_a = sel_fp ? f_wd_a : i_wd_a;
  assign m_wd_b = sel_fp ? f_wd_b : i_wd_b;
  assign m_we_a = sel_fp ? f_we_a : i_we_a;
  assign m_we_b = sel_fp ? f_we_b : i_we_b;
  assign m_busy = sel_fp ? f_busy : i_busy;
  assign m_done = sel_fp ? f_done : i_done;

  int n_checks = 0;
  int n_fail   = 0;

  int          wr_cnt [64];
  logic [31:0] wr_data[64];
  int          wr_cyc [64];
  int          cyc_we [80];
  int          cyc_busy[80];
  logic [5:0]  cyc_ra [80];
  logic [5:0]  cyc_rb [80];
  int tot_wr, collide, seen_b, done_cnt, done_cyc, stall_we, bad;

  // Starts a restore (accepted at edge 0) and records activity for cycles 1..max_cyc.
  // Entered and left just after a rising edge with rst low.
  task automatic run(input int max_cyc, input int stall_at, input int stall_len,
                     input int start_at, input int rst_at);
    for (int a = 0; a < 64; a++) begin
      wr_cnt[a] = 0; wr_data[a] = '0; wr_cyc[a] = 0;
    end
    for (int c = 0; c < 80; c++) begin
      cyc_we[c] = 0; cyc_busy[c] = 0; cyc_ra[c] = '0; cyc_rb[c] = '0;
    end
    tot_wr = 0; collide = 0; seen_b = 0; done_cnt = 0; done_cyc = 0; stall_we = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      stall = (c >= stall_at) && (c < stall_at + stall_len);
      start = (c == start_at);
      rst   = (c == rst_at);
      @(negedge clk);
      cyc_busy[c] = int'(m_busy);
      cyc_ra[c]   = m_ra_a;
      cyc_rb[c]   = m_rb_sample();
      if (m_we_a) begin
        wr_cnt[m_wa_a]++; wr_data[m_wa_a] = m_wd_a; wr_cyc[m_wa_a] = c; tot_wr++; cyc_we[c] = 1;
      end
      if (m_we_b) begin
        wr_cnt[m_wa_b]++; wr_data[m_wa_b] = m_wd_b; wr_cyc[m_wa_b] = c; tot_wr++; cyc_we[c] = 1;
        seen_b++;
      end
      if (m_we_a && m_we_b && m_wa_a == m_wa_b) collide++;
      if (stall && (m_we_a || m_we_b)) stall_we++;
      if (m_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      @(posedge clk); #1;
    end
    stall = 1'b0; start = 1'b0; rst = 1'b0;
  endtask

  function automatic logic [5:0] m_rb_sample();
    return m_ra_b;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; sel_fp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (i_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", i_busy); end
    n_checks++; if (i_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", i_done); end
    n_checks++;
    if ({i_we_a, i_we_b} !== 2'b00) begin
      n_fail++; $display("FAIL reset_we got %b want 00", {i_we_a, i_we_b});
    end
    n_checks++;
    if ({i_wa_a, i_wa_b} !== 10'd0) begin
      n_fail++; $display("FAIL reset_waddr got %h want 0", {i_wa_a, i_wa_b});
    end
    n_checks++;
    if ({i_wd_a, i_wd_b} !== 64'd0) begin
      n_fail++; $display("FAIL reset_wdata got %h want 0", {i_wd_a, i_wd_b});
    end
    n_checks++;
    if ({i_ra_a, i_ra_b} !== 10'd0) begin
      n_fail++; $display("FAIL reset_raddr got %h want 0", {i_ra_a, i_ra_b});
    end
    n_checks++; if (f_busy !== 1'b0) begin n_fail++; $display("FAIL reset_fp_busy got %b want 0", f_busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef RF_RESTORE_SINGLE_PORT_EN
  task automatic test_single_port();
    run(37, 0, 0, 0, 0);
    bad = 0;
    for (int a = 1; a < 32; a++) begin
      if (wr_cnt[a] != 1 || wr_data[a] !== 32'hA000_0000 + 32'(a) || wr_cyc[a] != a + 1) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sp_sequence got %0d bad want 0", bad); end
    n_checks++; if (tot_wr !== 31) begin n_fail++; $display("FAIL sp_total got %0d want 31", tot_wr); end
    n_checks++; if (seen_b !== 0) begin n_fail++; $display("FAIL sp_we_b got %0d want 0", seen_b); end
    n_checks++; if (wr_cnt[0] !== 0) begin n_fail++; $display("FAIL sp_addr0 got %0d want 0", wr_cnt[0]); end
    n_checks++; if (done_cyc !== 33) begin n_fail++; $display("FAIL sp_done_cyc got %0d want 33", done_cyc); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL sp_done_cnt got %0d want 1", done_cnt); end
    n_checks++; if (cyc_rb[1] !== 6'd0) begin n_fail++; $display("FAIL sp_raddr_b got %0d want 0", cyc_rb[1]); end
  endtask
`else
  task automatic test_int_restore();
    run(22, 0, 0, 0, 0);
    bad = 0;
    for (int a = 1; a < 32; a++) begin
      if (wr_cnt[a] != 1 || wr_data[a] !== 32'hA000_0000 + 32'(a)) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL int_data got %0d bad want 0", bad); end
    n_checks++; if (tot_wr !== 31) begin n_fail++; $display("FAIL int_total got %0d want 31", tot_wr); end
    n_checks++; if (wr_cnt[0] !== 0) begin n_fail++; $display("FAIL int_addr0 got %0d want 0", wr_cnt[0]); end
    n_checks++; if (wr_cyc[1] !== 2) begin n_fail++; $display("FAIL int_first_a got %0d want 2", wr_cyc[1]); end
    n_checks++; if (wr_cyc[2] !== 2) begin n_fail++; $display("FAIL int_first_b got %0d want 2", wr_cyc[2]); end
    n_checks++; if (wr_cyc[31] !== 17) begin n_fail++; $display("FAIL int_last got %0d want 17", wr_cyc[31]); end
    n_checks++; if (cyc_ra[1] !== 6'd1) begin n_fail++; $display("FAIL int_raddr_a got %0d want 1", cyc_ra[1]); end
    n_checks++; if (cyc_rb[1] !== 6'd2) begin n_fail++; $display("FAIL int_raddr_b got %0d want 2", cyc_rb[1]); end
    n_checks++; if (cyc_ra[16] !== 6'd31) begin n_fail++; $display("FAIL int_raddr_last got %0d want 31", cyc_ra[16]); end
    n_checks++; if (collide !== 0) begin n_fail++; $display("FAIL int_collide got %0d want 0", collide); end
    n_checks++; if (done_cyc !== 18) begin n_fail++; $display("FAIL int_done_cyc got %0d want 18", done_cyc); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL int_done_cnt got %0d want 1", done_cnt); end
    n_checks++; if (cyc_busy[18] !== 0) begin n_fail++; $display("FAIL int_busy_done got %0d want 0", cyc_busy[18]); end
    n_checks++; if (cyc_busy[17] !== 1) begin n_fail++; $display("FAIL int_busy_drain got %0d want 1", cyc_busy[17]); end
  endtask

  task automatic test_fp_bank();
    sel_fp = 1'b1;
    run(38, 0, 0, 0, 0);
    bad = 0;
    for (int a = 1; a < 64; a++) begin
      if (wr_cnt[a] != 1 || wr_data[a] !== 32'hA000_0000 + 32'(a)) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL fp_data got %0d bad want 0", bad); end
    n_checks++; if (tot_wr !== 63) begin n_fail++; $display("FAIL fp_total got %0d want 63", tot_wr); end
    n_checks++;
    if (wr_data[32] !== 32'hA000_0020) begin
      n_fail++; $display("FAIL fp_fp0 got %h want a0000020", wr_data[32]);
    end
    n_checks++; if (wr_cnt[0] !== 0) begin n_fail++; $display("FAIL fp_addr0 got %0d want 0", wr_cnt[0]); end
    n_checks++; if (done_cyc !== 34) begin n_fail++; $display("FAIL fp_done_cyc got %0d want 34", done_cyc); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL fp_done_cnt got %0d want 1", done_cnt); end
    sel_fp = 1'b0;
  endtask

  task automatic test_stall();
    // Pair (9,10) is presented in cycle 6; hold it for cycles 6..8.
    run(26, 6, 3, 0, 0);
    n_checks++; if (stall_we !== 0) begin n_fail++; $display("FAIL stall_we got %0d want 0", stall_we); end
    n_checks++;
    if (wr_cnt[9] !== 1 || wr_cnt[10] !== 1) begin
      n_fail++; $display("FAIL stall_pair_once got %0d/%0d want 1/1", wr_cnt[9], wr_cnt[10]);
    end
    n_checks++;
    if (wr_cyc[9] !== 9 || wr_cyc[10] !== 9) begin
      n_fail++; $display("FAIL stall_pair_cyc got %0d/%0d want 9/9", wr_cyc[9], wr_cyc[10]);
    end
    n_checks++; if (wr_cyc[11] !== 10) begin n_fail++; $display("FAIL stall_next got %0d want 10", wr_cyc[11]); end
    n_checks++; if (tot_wr !== 31) begin n_fail++; $display("FAIL stall_total got %0d want 31", tot_wr); end
    n_checks++; if (done_cyc !== 21) begin n_fail++; $display("FAIL stall_done got %0d want 21", done_cyc); end
  endtask

  task automatic test_reset_mid();
    // Reset sampled at the edge closing cycle 4, where pair (5,6) is written.
    run(25, 0, 0, 0, 4);
    n_checks++; if (tot_wr !== 6) begin n_fail++; $display("FAIL rmid_total got %0d want 6", tot_wr); end
    n_checks++; if (wr_cyc[6] !== 4) begin n_fail++; $display("FAIL rmid_pair got %0d want 4", wr_cyc[6]); end
    n_checks++; if (cyc_we[5] !== 0) begin n_fail++; $display("FAIL rmid_we got %0d want 0", cyc_we[5]); end
    n_checks++; if (cyc_busy[5] !== 0) begin n_fail++; $display("FAIL rmid_busy got %0d want 0", cyc_busy[5]); end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rmid_done got %0d want 0", done_cnt); end
    run(22, 0, 0, 0, 0);
    bad = 0;
    for (int a = 1; a < 32; a++) begin
      if (wr_cnt[a] != 1 || wr_data[a] !== 32'hA000_0000 + 32'(a)) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_clean got %0d bad want 0", bad); end
    n_checks++; if (done_cyc !== 18) begin n_fail++; $display("FAIL rmid_clean_done got %0d want 18", done_cyc); end
  endtask

  task automatic test_start_busy();
    run(22, 0, 0, 5, 0);
    n_checks++; if (tot_wr !== 31) begin n_fail++; $display("FAIL sbusy_total got %0d want 31", tot_wr); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL sbusy_done_cnt got %0d want 1", done_cnt); end
    n_checks++; if (done_cyc !== 18) begin n_fail++; $display("FAIL sbusy_done_cyc got %0d want 18", done_cyc); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef RF_RESTORE_SINGLE_PORT_EN
    test_single_port();
`else
    test_int_restore();
    test_fp_bank();
    test_stall();
    test_reset_mid();
    test_start_busy();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
